// File: rtl/program_flow_unit_if.sv
// Command bus between the instruction sequencer and the program flow unit.
// The master issues cmd_valid/cmd plus operands; the slave answers with ready.
interface program_flow_unit_if #(
   parameter int I_ADDR_WIDTH = 10
);
   logic                    cmd_valid;
   logic [2:0]              cmd;
   logic [I_ADDR_WIDTH-1:0] offset;
   logic                    br_cond;
   logic [I_ADDR_WIDTH-1:0] vector;
   logic                    ready;

   modport master (
      output cmd_valid, cmd, offset, br_cond, vector,
      input  ready
   );

   modport slave (
      input  cmd_valid, cmd, offset, br_cond, vector,
      output ready
   );
endinterface

// File: rtl/program_flow_unit.sv
// Program counter sequencer with return stack, interrupt enable flag and
// sticky stack-fault detection; FAULT blocks all commands until err_clr.
module program_flow_unit #(
   parameter int I_ADDR_WIDTH = 10,
   parameter int STACK_DEPTH  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   program_flow_unit_if.slave                 cmd_bus,
   input  logic                               sei,
   input  logic                               cli,
   input  logic                               err_clr,
   output logic [I_ADDR_WIDTH-1:0]            program_counter,
   output logic                               irq_enable,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
   output logic                               overflow,
   output logic                               underflow
);
   localparam int LW = $clog2(STACK_DEPTH + 1);
   localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(STACK_DEPTH);

   localparam logic [2:0] CMD_INC  = 3'd1;
   localparam logic [2:0] CMD_JMP  = 3'd2;
   localparam logic [2:0] CMD_BR   = 3'd3;
   localparam logic [2:0] CMD_CALL = 3'd4;
   localparam logic [2:0] CMD_RET  = 3'd5;
   localparam logic [2:0] CMD_RETI = 3'd6;
   localparam logic [2:0] CMD_ISR  = 3'd7;

   typedef enum logic {RUN, FAULT} state_t;

   state_t                  state, state_next;
   logic [I_ADDR_WIDTH-1:0] pc, pc_next, pc_inc, pc_rel, push_data, stack_top;
   logic [I_ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [LW-1:0]           level, level_next;
   logic [PW-1:0]           top_idx;
   logic                    irq, irq_next, ovf, unf;
   logic                    accept, is_push, is_pop, push_ok, pop_ok;
   logic                    ovf_event, unf_event;

   // Command decode and stack bookkeeping shared by the state and datapath logic
   always_comb begin
      accept    = cmd_bus.cmd_valid && (state == RUN);
      is_push   = accept && ((cmd_bus.cmd == CMD_CALL) || (cmd_bus.cmd == CMD_ISR));
      is_pop    = accept && ((cmd_bus.cmd == CMD_RET) || (cmd_bus.cmd == CMD_RETI));
      push_ok   = is_push && (level != FULL_LEVEL);
      pop_ok    = is_pop && (level != '0);
      ovf_event = is_push && (level == FULL_LEVEL);
      unf_event = is_pop && (level == '0);
      pc_inc    = pc + I_ADDR_WIDTH'(1);
      pc_rel    = pc_inc + cmd_bus.offset;
      push_data = (cmd_bus.cmd == CMD_ISR) ? pc : pc_inc;
      top_idx   = (level == '0) ? '0 : PW'(level - LW'(1));
      stack_top = stack_mem[top_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (ovf_event || unf_event) state_next = FAULT;
         FAULT:   if (err_clr)                state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      cmd_bus.ready   = (state == RUN);
      program_counter = pc;
      irq_enable      = irq;
      stack_level     = level;
      overflow        = ovf;
      underflow       = unf;
   end

   // A faulting push/pop leaves irq alone, so sei/cli are dropped that cycle too
   always_comb begin
      pc_next    = pc;
      level_next = level;
      irq_next   = irq;
      if ((state == RUN) && !ovf_event && !unf_event) begin
         if (cli)      irq_next = 1'b0;
         else if (sei) irq_next = 1'b1;
      end
      if (accept) begin
         case (cmd_bus.cmd)
            CMD_INC:  pc_next = pc_inc;
            CMD_JMP:  pc_next = pc_rel;
            CMD_BR:   pc_next = cmd_bus.br_cond ? pc_rel : pc_inc;
            CMD_CALL: if (push_ok) begin
               pc_next    = pc_rel;
               level_next = level + LW'(1);
            end
            CMD_ISR:  if (push_ok) begin
               pc_next    = cmd_bus.vector;
               irq_next   = 1'b0;
               level_next = level + LW'(1);
            end
            CMD_RET:  if (pop_ok) begin
               pc_next    = stack_top;
               level_next = level - LW'(1);
            end
            CMD_RETI: if (pop_ok) begin
               pc_next    = stack_top;
               irq_next   = 1'b1;
               level_next = level - LW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc    <= '0;
         level <= '0;
         irq   <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         pc    <= pc_next;
         level <= level_next;
         irq   <= irq_next;
         if (ovf_event)                      ovf <= 1'b1;
         else if ((state == FAULT) && err_clr) ovf <= 1'b0;
         if (unf_event)                      unf <= 1'b1;
         else if ((state == FAULT) && err_clr) unf <= 1'b0;
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset
   always_ff @(posedge clk) begin
      if (push_ok) stack_mem[PW'(level)] <= push_data;
   end
endmodule

// File: doc/program_flow_unit.md
PROGRAM_FLOW_UNIT -- requirements
Module: program_flow_unit

Interface
REQ-001 SHALL have parameter I_ADDR_WIDTH, default 10, program counter width in instruction words.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command strobe.
REQ-006 SHALL have port cmd  input  3  command code: 0 reserved, 1 INC, 2 JMP, 3 BR, 4 CALL, 5 RET, 6 RETI, 7 ISR.
REQ-007 SHALL have port offset  input  I_ADDR_WIDTH  relative displacement, two's complement.
REQ-008 SHALL have port br_cond  input  1  branch-taken condition for BR.
REQ-009 SHALL have port vector  input  I_ADDR_WIDTH  ISR target address.
REQ-010 SHALL have ports sei and cli  input  1 each  set/clear global interrupt enable.
REQ-011 SHALL have port err_clr  input  1  fault acknowledge.
REQ-012 SHALL have port program_counter  output  I_ADDR_WIDTH  current PC, registered.
REQ-013 SHALL have port ready  output  1  high when commands are accepted.
REQ-014 SHALL have port irq_enable  output  1  global interrupt-enable flag, registered.
REQ-015 SHALL have port stack_level  output  $clog2(STACK_DEPTH+1)  occupied entries.
REQ-016 SHALL have ports overflow and underflow  output  1 each  sticky fault causes.

Function
REQ-017 SHALL implement a two-state FSM, RUN and FAULT; ready = (state == RUN).
REQ-018 A command SHALL be accepted only on a clock edge where cmd_valid && ready; it completes in that edge (latency 1). cmd 0, or cmd_valid low, SHALL leave all state unchanged.
REQ-019 INC: PC <= PC+1.
REQ-020 JMP: PC <= PC+1+offset.
REQ-021 BR: br_cond=1 gives PC <= PC+1+offset; br_cond=0 gives PC <= PC+1.
REQ-022 CALL: push PC+1; PC <= PC+1+offset; stack_level +1.
REQ-023 ISR: push PC (current, not incremented); PC <= vector; irq_enable <= 0; stack_level +1. ISR SHALL be accepted regardless of irq_enable.
REQ-024 RET: PC <= popped entry; stack_level -1.
REQ-025 RETI: same as RET, plus irq_enable <= 1.
REQ-026 All PC arithmetic SHALL be modulo 2^I_ADDR_WIDTH; 0x3FF+1 wraps to 0 at the default width.
REQ-027 The stack SHALL be LIFO; a pop returns the most recent unpopped push.
REQ-028 CALL or ISR with stack_level == STACK_DEPTH SHALL NOT push or change PC or irq_enable, SHALL set overflow, and SHALL move the FSM to FAULT.
REQ-029 RET or RETI with stack_level == 0 SHALL NOT change PC or irq_enable, SHALL set underflow, and SHALL move the FSM to FAULT.
REQ-030 In FAULT, all commands, sei and cli SHALL be ignored.
REQ-031 err_clr in FAULT SHALL clear overflow and underflow and return the FSM to RUN on the next edge; stack_level and PC are unchanged. err_clr in RUN has no effect.
REQ-032 sei/cli in RUN SHALL update irq_enable at the edge. cli wins over sei. Both SHALL be overridden by an accepted ISR (clears irq_enable) or RETI (sets irq_enable) in the same cycle.

Reset
REQ-033 While reset is low, the block SHALL immediately (no clock needed) force:
- PC = 0, stack_level = 0, irq_enable = 0
- overflow = 0, underflow = 0
- state RUN, ready = 1
Stack entry contents are don't-care. This applies at any point, including mid-sequence or in FAULT.

Verification
REQ-034 Bench SHALL cover, at default parameters unless noted, each scenario below:
- Reset release, three INC -> PC = 3.
- PC = 5, CALL offset = 10 -> PC = 16, level 1; then RET -> PC = 6, level 0.
- PC = 0x3FF, INC -> PC = 0; then INC, JMP offset = 0x3FE -> PC = 0.
- sei; PC = 7, ISR vector = 0x20 -> PC = 0x20, irq_enable = 0, level 1; RETI -> PC = 7, irq_enable = 1, level 0.
- STACK_DEPTH = 2, two CALLs, third CALL -> overflow = 1, ready = 0, PC and level unchanged; INC ignored; err_clr -> ready = 1, overflow = 0, level = 2. Separately, RET at level 0 -> underflow = 1.
- Level 2 with irq_enable = 1, reset low between clock edges -> PC, level and irq_enable read 0 before the next edge.
